// File: rtl/multicycle_stall_ctrl.sv
// Stall controller for long-latency EX units: each unit is either counted
// (fixed latency) or handshaked (waits for its ready, with a timeout).
module multicycle_stall_ctrl #(
  parameter int                      NUNITS    = 2,
  parameter int                      CNTW      = 5,
  parameter logic [NUNITS*CNTW-1:0]  LATENCIES = {5'd0, 5'd8},
  parameter logic [NUNITS-1:0]       HSMASK    = 2'b10,
  parameter int                      TIMEOUT   = 64,
  parameter int                      TOW       = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEX_Valid,
  input  logic [NUNITS-1:0] iEX_UnitSel,
  input  logic [NUNITS-1:0] iUnitReady,
  input  logic              iFlush,
  output logic              oStall,
  output logic [NUNITS-1:0] oUnitStart,
  output logic [NUNITS-1:0] oUnitAbort,
  output logic              oBusy,
  output logic [NUNITS-1:0] oActiveUnit,
  output logic              oTimeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Counting the start cycle, a handshake unit stalls TIMEOUT cycles in total,
  // so WAIT gives up when the counter holds TIMEOUT-2.
  localparam logic [TOW-1:0]  TO_LAST  = TOW'(TIMEOUT - 2);
  localparam logic [CNTW-1:0] LAT_ONE  = CNTW'(1);

  state_t            r_state;
  logic [CNTW-1:0]   r_lat_cnt;
  logic [TOW-1:0]    r_to_cnt;
  logic [NUNITS-1:0] r_active;
  logic              r_timeout;

  state_t            w_state_nxt;
  logic [CNTW-1:0]   w_lat_nxt;
  logic [TOW-1:0]    w_to_nxt;
  logic [NUNITS-1:0] w_active_nxt;
  logic              w_to_set;

  logic [NUNITS-1:0] w_sel_oh;
  logic [CNTW-1:0]   w_sel_lat;
  logic              w_sel_hs;
  logic              w_req;
  logic              w_act_hs;
  logic              w_act_ready;

  // Lowest set bit of the select vector wins.
  assign w_sel_oh = iEX_UnitSel & (~iEX_UnitSel + NUNITS'(1));

  always_comb begin
    w_sel_lat = '0;
    w_sel_hs  = 1'b0;
    for (int i = 0; i < NUNITS; i++) begin
      if (w_sel_oh[i]) begin
        w_sel_lat = LATENCIES[i*CNTW +: CNTW];
        w_sel_hs  = HSMASK[i];
      end
    end
  end

  // A fixed unit with zero latency is not multicycle at all.
  assign w_req       = iEX_Valid && (|w_sel_oh) && !iFlush && (w_sel_hs || (w_sel_lat != '0));
  assign w_act_hs    = |(HSMASK & r_active);
  assign w_act_ready = |(iUnitReady & r_active);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_lat_nxt    = r_lat_cnt;
    w_to_nxt     = r_to_cnt;
    w_active_nxt = r_active;
    w_to_set     = 1'b0;
    oStall       = 1'b0;
    oUnitStart   = '0;
    oUnitAbort   = '0;

    if (iFlush) begin
      w_state_nxt  = S_IDLE;
      w_lat_nxt    = '0;
      w_to_nxt     = '0;
      w_active_nxt = '0;
      if (r_state == S_WAIT) oUnitAbort = r_active;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            oStall       = 1'b1;
            oUnitStart   = w_sel_oh;
            w_active_nxt = w_sel_oh;
            w_to_nxt     = '0;
            w_lat_nxt    = w_sel_lat - LAT_ONE;
            w_state_nxt  = (!w_sel_hs && w_sel_lat == LAT_ONE) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_act_hs) begin
            if (w_act_ready) begin
              // Result is ready: release the pipeline this very cycle.
              w_state_nxt  = S_IDLE;
              w_active_nxt = '0;
              w_to_nxt     = '0;
            end else begin
              oStall = 1'b1;
              if (r_to_cnt == TO_LAST) begin
                w_state_nxt = S_DONE;
                w_to_set    = 1'b1;
              end else begin
                w_to_nxt = r_to_cnt + TOW'(1);
              end
            end
          end else begin
            oStall = 1'b1;
            if (r_lat_cnt == LAT_ONE) w_state_nxt = S_DONE;
            else                      w_lat_nxt   = r_lat_cnt - LAT_ONE;
          end
        end
        S_DONE: begin
          w_state_nxt  = S_IDLE;
          w_active_nxt = '0;
          w_lat_nxt    = '0;
          w_to_nxt     = '0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_to_cnt  <= '0;
      r_active  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_to_cnt  <= w_to_nxt;
      r_active  <= w_active_nxt;
      r_timeout <= r_timeout | w_to_set;
    end
  end

  assign oBusy       = (r_state != S_IDLE);
  assign oActiveUnit = r_active;
  assign oTimeout    = r_timeout;

endmodule

// File: tb/tb_multicycle_stall_ctrl.sv
// Bench for multicycle_stall_ctrl: two instances (default units, and a
// LAT=0 / LAT=1 fixed pair) checked every cycle against a remaining-cycles model.
module tb_multicycle_stall_ctrl;

  localparam int TIMEOUT = 64;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iEX_Valid;
  logic [1:0] iEX_UnitSel;
  logic [1:0] iUnitReady;
  logic       iFlush;

  logic       a_stall, b_stall, a_busy, b_busy, a_to, b_to;
  logic [1:0] a_start, b_start, a_abort, b_abort, a_act, b_act;

  always #5 iCLK = ~iCLK;

  multicycle_stall_ctrl dut_a (
    .iCLK(iCLK), .iRST(iRST), .iEX_Valid(iEX_Valid), .iEX_UnitSel(iEX_UnitSel),
    .iUnitReady(iUnitReady), .iFlush(iFlush), .oStall(a_stall), .oUnitStart(a_start),
    .oUnitAbort(a_abort), .oBusy(a_busy), .oActiveUnit(a_act), .oTimeout(a_to)
  );

  multicycle_stall_ctrl #(
    .LATENCIES({5'd1, 5'd0}), .HSMASK(2'b00)
  ) dut_b (
    .iCLK(iCLK), .iRST(iRST), .iEX_Valid(iEX_Valid), .iEX_UnitSel(iEX_UnitSel),
    .iUnitReady(iUnitReady), .iFlush(iFlush), .oStall(b_stall), .oUnitStart(b_start),
    .oUnitAbort(b_abort), .oBusy(b_busy), .oActiveUnit(b_act), .oTimeout(b_to)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per instance, the unit in flight (-1 = none) and how many more
  // stalled cycles it may still take; 0 remaining means the release cycle.
  int m_unit[2];
  int m_left[2];
  bit m_to[2];

  int cyc = 0;
  int a_stall_cnt, b_stall_cnt, a_start_cnt, a_abort_cnt, a_busy_cnt;
  int start_at[$];
  logic [1:0] start_val[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(int inst, int u);
    if (inst == 0) return (u == 0) ? 8 : 0;
    return (u == 0) ? 0 : 1;
  endfunction

  function automatic bit hs_of(int inst, int u);
    return (inst == 0) && (u == 1);
  endfunction

  function automatic int low_sel(logic [1:0] s);
    if (s[0]) return 0;
    if (s[1]) return 1;
    return -1;
  endfunction

  function automatic bit accepts(int inst);
    int u;
    u = low_sel(iEX_UnitSel);
    return iEX_Valid && !iFlush && (u >= 0) && (hs_of(inst, u) || lat_of(inst, u) != 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_unit[k] = -1;
      m_left[k] = 0;
      m_to[k]   = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic       e_stall;
      logic [1:0] e_start, e_abort, e_act;
      string      p;
      int         u;
      p       = (k == 0) ? "a" : "b";
      u       = low_sel(iEX_UnitSel);
      e_stall = 1'b0;
      e_start = 2'b00;
      e_abort = 2'b00;
      e_act   = (m_unit[k] >= 0) ? 2'(1 << m_unit[k]) : 2'b00;
      if (m_unit[k] < 0) begin
        if (accepts(k)) begin
          e_stall = 1'b1;
          e_start = 2'(1 << u);
        end
      end else if (m_left[k] > 0) begin
        if (iFlush)                                          e_abort = e_act;
        else if (!(hs_of(k, m_unit[k]) && iUnitReady[m_unit[k]])) e_stall = 1'b1;
      end
      check({p, ".stall"},  (k == 0) ? a_stall : b_stall, e_stall);
      check({p, ".start"},  (k == 0) ? a_start : b_start, e_start);
      check({p, ".abort"},  (k == 0) ? a_abort : b_abort, e_abort);
      check({p, ".busy"},   (k == 0) ? a_busy  : b_busy,  m_unit[k] >= 0);
      check({p, ".active"}, (k == 0) ? a_act   : b_act,   e_act);
      check({p, ".timeout"},(k == 0) ? a_to    : b_to,    m_to[k]);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int u;
      u = low_sel(iEX_UnitSel);
      if (iFlush) begin
        m_unit[k] = -1;
        m_left[k] = 0;
      end else if (m_unit[k] < 0) begin
        if (accepts(k)) begin
          m_unit[k] = u;
          m_left[k] = hs_of(k, u) ? TIMEOUT - 1 : lat_of(k, u) - 1;
        end
      end else if (m_left[k] > 0) begin
        if (hs_of(k, m_unit[k]) && iUnitReady[m_unit[k]]) begin
          m_unit[k] = -1;
        end else begin
          m_left[k]--;
          if (m_left[k] == 0 && hs_of(k, m_unit[k])) m_to[k] = 1'b1;
        end
      end else begin
        m_unit[k] = -1;
      end
    end
  endtask

  task automatic clr_counts();
    a_stall_cnt = 0; b_stall_cnt = 0; a_start_cnt = 0; a_abort_cnt = 0; a_busy_cnt = 0;
    start_at.delete();
    start_val.delete();
  endtask

  task automatic cycle(input logic v, input logic [1:0] sel, input logic [1:0] rdy, input logic fl);
    @(negedge iCLK);
    iEX_Valid   = v;
    iEX_UnitSel = sel;
    iUnitReady  = rdy;
    iFlush      = fl;
    #1;
    check_outputs();
    if (a_stall)        a_stall_cnt++;
    if (b_stall)        b_stall_cnt++;
    if (a_abort != 0)   a_abort_cnt++;
    if (a_busy)         a_busy_cnt++;
    if (a_start != 0) begin
      a_start_cnt++;
      start_at.push_back(cyc);
      start_val.push_back(a_start);
    end
    @(posedge iCLK);
    model_step();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    iRST = 1'b1; iEX_Valid = 1'b0; iEX_UnitSel = 2'b00; iUnitReady = 2'b00; iFlush = 1'b0;
    model_reset();
    #1;
    check("reset.a_stall", a_stall, 1'b0);
    check("reset.a_busy",  a_busy,  1'b0);
    check("reset.a_to",    a_to,    1'b0);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    idle(2);

    // Unit0 fixed LAT=8: eight stalls, one start, then the release cycle.
    clr_counts();
    for (int i = 0; i < 9; i++) cycle(1'b1, 2'b01, 2'b00, 1'b0);
    idle(3);
    check("lat8.stall_cycles", a_stall_cnt, 8);
    check("lat8.starts",       a_start_cnt, 1);
    check("lat8.busy_cycles",  a_busy_cnt,  8);
    check("lat0.b_no_stall",   b_stall_cnt, 0);

    // Unit1 handshake, ready three cycles after start.
    clr_counts();
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b10, 2'b00, 1'b0);
    cycle(1'b1, 2'b10, 2'b10, 1'b0);
    idle(2);
    check("hs3.stall_cycles", a_stall_cnt, 3);
    check("hs3.timeout_low",  a_to, 1'b0);

    // Unit1 handshake never ready: timeout after 64 stalls, sticky flag.
    clr_counts();
    for (int i = 0; i < TIMEOUT + 1; i++) cycle(1'b1, 2'b10, 2'b00, 1'b0);
    idle(2);
    check("to.stall_cycles", a_stall_cnt, TIMEOUT);
    check("to.flag_set",     a_to, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 2'b01, 2'b00, 1'b0);
    idle(1);
    check("to.flag_sticky",  a_to, 1'b1);

    // Flush at cycle 4 of a unit0 operation.
    clr_counts();
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b01, 2'b00, 1'b0);
    cycle(1'b1, 2'b01, 2'b00, 1'b1);
    idle(3);
    check("flush.aborts",       a_abort_cnt, 1);
    check("flush.stall_cycles", a_stall_cnt, 3);
    check("flush.busy_cycles",  a_busy_cnt,  3);

    // Back-to-back: 2'b11 picks unit0, then unit1 starts right after DONE.
    clr_counts();
    for (int i = 0; i < 9; i++) cycle(1'b1, 2'b11, 2'b00, 1'b0);
    cycle(1'b1, 2'b10, 2'b00, 1'b0);
    cycle(1'b1, 2'b10, 2'b10, 1'b0);
    idle(2);
    check("b2b.starts",       a_start_cnt, 2);
    check("b2b.stall_cycles", a_stall_cnt, 9);
    if (start_val.size() == 2) begin
      check("b2b.first_unit",  start_val[0], 2'b01);
      check("b2b.second_unit", start_val[1], 2'b10);
      check("b2b.gap",         start_at[1] - start_at[0], 9);
    end else begin
      check("b2b.start_count", start_val.size(), 2);
    end

    // LAT=1 fixed unit on instance b: one stall then release.
    clr_counts();
    cycle(1'b1, 2'b10, 2'b00, 1'b0);
    cycle(1'b1, 2'b10, 2'b00, 1'b0);
    idle(2);
    check("lat1.b_stall_cycles", b_stall_cnt, 1);

    // Asynchronous reset in the middle of a WAIT.
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b01, 2'b00, 1'b0);
    @(posedge iCLK);
    #2;
    iEX_Valid = 1'b0; iEX_UnitSel = 2'b00; iUnitReady = 2'b00; iFlush = 1'b0;
    iRST = 1'b1;
    #1;
    check("rst_mid.stall",  a_stall, 1'b0);
    check("rst_mid.busy",   a_busy,  1'b0);
    check("rst_mid.active", a_act,   2'b00);
    check("rst_mid.abort",  a_abort, 2'b00);
    check("rst_mid.to",     a_to,    1'b0);
    model_reset();
    @(negedge iCLK);
    iRST = 1'b0;
    idle(2);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic       v, fl;
      logic [1:0] sel, rdy;
      v   = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      rdy = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      fl  = ($urandom_range(0, 19) == 0);
      cycle(v, sel, rdy, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_stall_ctrl.md
Name: multicycle_stall_ctrl

Overview:
- Parametrised stall controller for long-latency execution units in the EX stage (DIVREM, FPULA, future units).
- Replaces the fixed 8-cycle DIVREM counter with N units. Each unit is configured as either fixed-latency (counted) or handshake (waits for unit ready), with timeout protection.
- Drives a whole-pipeline stall and per-unit start/abort pulses. Sits beside the forward/hazard unit; its oStall is ORed into all five stage stalls.

Parameters:
NUNITS, 2, number of multicycle units.
CNTW, 5, width of each latency field and of the latency counter.
LATENCIES, {5'd0,5'd8}, packed NUNITS*CNTW. Unit i latency = LATENCIES[i*CNTW +: CNTW]; 0 = not multicycle (ignored in fixed mode).
HSMASK, 2'b10, bit i = 1 makes unit i a handshake unit; bit i = 0 makes it a fixed-latency unit.
TIMEOUT, 64, maximum WAIT cycles for a handshake unit before forced completion.
TOW, 8, width of the timeout counter; TIMEOUT < 2^TOW.

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-high
iEX_Valid  in  1  EX holds a real (non-bubble) instruction
iEX_UnitSel  in  NUNITS  unit used by the EX instruction; one-hot expected, lowest set index wins
iUnitReady  in  NUNITS  result-ready from each handshake unit
iFlush  in  1  MEM exception flush; highest priority
oStall  out  1  stall IF..WB (combinational)
oUnitStart  out  NUNITS  one-cycle start pulse to the selected unit (combinational)
oUnitAbort  out  NUNITS  one-cycle abort to the busy unit on flush (combinational)
oBusy  out  1  FSM is not IDLE (registered)
oActiveUnit  out  NUNITS  one-hot of the unit being waited on (registered)
oTimeout  out  1  sticky; set on any handshake timeout, cleared only by iRST

Behaviour:
- Reset: state IDLE; latency counter, timeout counter, oActiveUnit, oTimeout all 0. Consequently oStall, oUnitStart, oUnitAbort, oBusy are all 0.
- States: IDLE, WAIT, DONE.
- Request: iEX_Valid && sel!=0 && !iFlush, where sel is the lowest set bit of iEX_UnitSel.
  - Request is ignored (no stall, no start) if sel is a fixed-latency unit with LAT=0.
- IDLE, on request:
  - oStall=1 and oUnitStart[sel]=1 in the same cycle.
  - Next state WAIT, with oActiveUnit<=sel, latency counter<=LAT-1 for fixed units, timeout counter<=0.
  - Exception: a fixed unit with LAT=1 goes directly to DONE.
- WAIT, fixed-latency unit:
  - oStall=1. Counter decrements each cycle; at counter==1 next state is DONE.
  - Total stall cycles = LAT exactly (LAT=8 gives 8, matching the current DIVREM behaviour).
- WAIT, handshake unit:
  - oStall=1 while iUnitReady[active]==0. In a cycle where iUnitReady[active]==1, oStall=0 that same cycle and next state is IDLE; the instruction advances at that edge.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT-1 with no ready: next state DONE and oTimeout<=1.
- DONE:
  - oStall=0 for one cycle so the EX instruction leaves EX. New requests are not accepted in this cycle.
  - Next state IDLE; oActiveUnit<=0.
- iFlush, any state:
  - oStall=0 combinationally. oUnitAbort[oActiveUnit]=1 if state is WAIT.
  - Next state IDLE; counters and oActiveUnit cleared. oTimeout is retained.
- Back-to-back: the next multicycle instruction is seen in IDLE the cycle after DONE (or after the handshake-ready cycle) and restarts normally.
- iEX_UnitSel changes during WAIT are ignored; oActiveUnit governs.
- iRST mid-operation: immediate return to reset values; no abort pulse is generated.

Test Plan:
- Unit0 fixed LAT=8, single request → oStall high for exactly 8 cycles, oUnitStart[0] for 1 cycle, then 1 unstalled DONE cycle, then IDLE.
- Unit1 handshake, iUnitReady[1] asserted 3 cycles after start → oStall high for 3 cycles, low in the ready cycle, oTimeout stays 0.
- Unit1 handshake, never ready, TIMEOUT=64 → 64 stall cycles, then DONE; oTimeout=1 and remains 1 after further operations.
- iFlush at cycle 4 of a unit0 operation → oStall=0 that cycle, oUnitAbort[0]=1 for 1 cycle, IDLE next cycle.
- Back-to-back unit0 then unit1, plus iEX_UnitSel=2'b11 → unit0 chosen; second op starts the cycle after DONE.
- iRST asserted during WAIT → all outputs 0 asynchronously; LAT=0 unit request → no stall.
